// File: rtl/bitwise_unit_arbiter.sv
// Two requesters share a single registered NOT/AND/OR/XOR unit through an IDLE -> EXEC -> RESP FSM.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin contention; the default is fixed priority to requester 0.
module bitwise_unit_arbiter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [1:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [1:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   input  logic         rsp_ready,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state;
   logic         last_grant;
   logic         grant;
   logic         any_valid;
   logic         accept;
   logic [1:0]   op_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         id_q;
   logic [W-1:0] result;

   // Arbitration: a lone valid always wins; contention is resolved by the build-time policy.
   always_comb begin
      any_valid = req0_valid || req1_valid;
      grant     = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant = ~last_grant;
`else
         grant = 1'b0;
`endif
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

`ifndef ARB_ROUND_ROBIN_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   assign accept     = (state == IDLE) && !rst && any_valid;
   assign req0_ready = accept && (grant == 1'b0);
   assign req1_ready = accept && (grant == 1'b1);
   assign busy       = (state != IDLE);

   always_comb begin
      result = '0;
      case (op_q)
         2'b00:   result = ~a_q;
         2'b01:   result = a_q & b_q;
         2'b10:   result = a_q | b_q;
         default: result = a_q ^ b_q;
      endcase
   end

   // Reset discards any in-flight op and wins over a same-cycle response handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         last_grant <= 1'b1;
         op_q       <= 2'b00;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_q       <= grant ? req1_op : req0_op;
                  a_q        <= grant ? req1_a  : req0_a;
                  b_q        <= grant ? req1_b  : req0_b;
                  id_q       <= grant;
                  last_grant <= grant;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= result;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Self-checking bench for bitwise_unit_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design when choosing expected grants.
module tb_bitwise_unit_arbiter;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [1:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_ready, busy;
   logic [W-1:0] rsp_data;

   logic         rst_i;
   logic         rdy;
   logic         v [2];
   logic [1:0]   op [2];
   logic [W-1:0] a [2];
   logic [W-1:0] b [2];
   logic         lastg;
   int           tests_run;
   int           tests_failed;

   bitwise_unit_arbiter #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
         2'b00:   return ~x;
         2'b01:   return x & y;
         2'b10:   return x | y;
         default: return x ^ y;
      endcase
   endfunction

   function automatic logic ref_grant(input logic v0, input logic v1, input logic last);
      if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !last;
`else
         return 1'b0;
`endif
      end
      return v1;
   endfunction

   // Inputs change one time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      rst        = rst_i;
      rsp_ready  = rdy;
      req0_valid = v[0];
      req0_op    = op[0];
      req0_a     = a[0];
      req0_b     = b[0];
      req1_valid = v[1];
      req1_op    = op[1];
      req1_a     = a[1];
      req1_b     = b[1];
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      v     = '{1'b0, 1'b0};
      applyStimulus();
      rst_i = 1'b0;
      applyStimulus();
      lastg = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      rdy   = 1'b0;
      v     = '{1'b1, 1'b1};
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_data} !== 9'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got %b expected 0", {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_data});
      end
      rst_i = 1'b0;
      v     = '{1'b0, 1'b0};
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid, rsp_data} !== 8'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release: got %b expected 0", {req0_ready, req1_ready, busy, rsp_valid, rsp_data});
      end
      lastg = 1'b1;
   endtask

   task automatic test_not_req0();
      logic [3:0] exp_vec [4];
      exp_vec = '{4'b1000, 4'b0010, 4'b0011, 4'b0000};
      rdy   = 1'b1;
      v[0]  = 1'b1;
      op[0] = 2'b00;
      a[0]  = 4'b1000;
      b[0]  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         @(negedge clk);
         v[0] = 1'b0;
         tests_run++;
         if ({req0_ready, req1_ready, busy, rsp_valid} !== exp_vec[i]) begin
            tests_failed++;
            $display("[TB] FAIL not_timing[%0d]: got %b expected %b", i, {req0_ready, req1_ready, busy, rsp_valid}, exp_vec[i]);
         end
         if (i == 2) begin
            tests_run++;
            if ({rsp_id, rsp_data} !== {1'b0, 4'b0111}) begin
               tests_failed++;
               $display("[TB] FAIL not_result: got %b expected 00111", {rsp_id, rsp_data});
            end
         end
      end
   endtask

   task automatic test_xor_stall();
      do_reset();
      rdy   = 1'b0;
      v[1]  = 1'b1;
      op[1] = 2'b11;
      a[1]  = 4'b1101;
      b[1]  = 4'b0101;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL xor_accept: got %b expected 0100", {req0_ready, req1_ready, busy, rsp_valid});
      end
      v[1]  = 1'b0;
      v[0]  = 1'b1;
      op[0] = 2'b01;
      a[0]  = 4'b1100;
      b[0]  = 4'b1010;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL xor_exec: got %b expected 0010", {req0_ready, req1_ready, busy, rsp_valid});
      end
      for (int i = 0; i < 6; i++) begin
         if (i == 5) rdy = 1'b1;
         applyStimulus();
         @(negedge clk);
         tests_run++;
         if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_data} !== {4'b0011, 1'b1, 4'b1000}) begin
            tests_failed++;
            $display("[TB] FAIL xor_hold[%0d]: got %b expected 001111000", i, {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_data});
         end
      end
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL xor_release_next: got %b expected 1000", {req0_ready, req1_ready, busy, rsp_valid});
      end
      v[0] = 1'b0;
      applyStimulus();
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'b1000}) begin
         tests_failed++;
         $display("[TB] FAIL and_after_stall: got %b expected 101000", {rsp_valid, rsp_id, rsp_data});
      end
   endtask

   task automatic test_contention();
      logic [W-1:0] exp_data [$];
      logic         exp_id [$];
      logic         exp_g;
      int           grants;
      int           rsps;
      do_reset();
      rdy    = 1'b1;
      v      = '{1'b1, 1'b1};
      op     = '{2'b01, 2'b10};
      a      = '{W'($urandom), W'($urandom)};
      b      = '{W'($urandom), W'($urandom)};
      grants = 0;
      rsps   = 0;
      for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
         applyStimulus();
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            exp_g = ref_grant(1'b1, 1'b1, lastg);
            tests_run++;
            if ({req0_ready, req1_ready} !== (exp_g ? 2'b01 : 2'b10)) begin
               tests_failed++;
               $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", grants, {req0_ready, req1_ready}, (exp_g ? 2'b01 : 2'b10));
            end
            exp_data.push_back(ref_op(op[exp_g], a[exp_g], b[exp_g]));
            exp_id.push_back(exp_g);
            lastg     = exp_g;
            a[exp_g]  = W'($urandom);
            b[exp_g]  = W'($urandom);
            grants++;
         end
         if (rsp_valid) begin
            tests_run++;
            if (exp_data.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL contention_spurious: got rsp id %b data %b expected none", rsp_id, rsp_data);
            end else if ({rsp_id, rsp_data} !== {exp_id[0], exp_data[0]}) begin
               tests_failed++;
               $display("[TB] FAIL contention_rsp[%0d]: got %b expected %b", rsps, {rsp_id, rsp_data}, {exp_id[0], exp_data[0]});
            end
            if (exp_data.size() != 0) begin
               void'(exp_data.pop_front());
               void'(exp_id.pop_front());
            end
            rsps++;
         end
      end
      tests_run++;
      if (rsps != 4) begin
         tests_failed++;
         $display("[TB] FAIL contention_budget: got %0d responses expected 4", rsps);
      end
      v = '{1'b0, 1'b0};
   endtask

   task automatic test_rst_exec();
      do_reset();
      rdy   = 1'b1;
      v[0]  = 1'b1;
      op[0] = 2'b10;
      a[0]  = 4'b0011;
      b[0]  = 4'b0100;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL rst_exec_accept: got %b expected 1000", {req0_ready, req1_ready, busy, rsp_valid});
      end
      v[0]  = 1'b0;
      rst_i = 1'b1;
      applyStimulus();
      rst_i = 1'b0;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({busy, rsp_valid, rsp_data} !== 6'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_exec_discard: got %b expected 000000", {busy, rsp_valid, rsp_data});
      end
      v[1]  = 1'b1;
      op[1] = 2'b01;
      a[1]  = 4'b1111;
      b[1]  = 4'b0101;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL rst_exec_next_accept: got %b expected 0100", {req0_ready, req1_ready, busy, rsp_valid});
      end
      v[1] = 1'b0;
      applyStimulus();
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 4'b0101}) begin
         tests_failed++;
         $display("[TB] FAIL rst_exec_next_rsp: got %b expected 110101", {rsp_valid, rsp_id, rsp_data});
      end
   endtask

   task automatic test_drop_valid();
      logic [W-1:0] exp0;
      do_reset();
      rdy   = 1'b0;
      v[0]  = 1'b1;
      op[0] = 2'b11;
      a[0]  = W'($urandom);
      b[0]  = W'($urandom);
      exp0  = ref_op(op[0], a[0], b[0]);
      applyStimulus();
      @(negedge clk);
      v[0]  = 1'b0;
      v[1]  = 1'b1;
      op[1] = 2'($urandom_range(0, 3));
      a[1]  = W'($urandom);
      b[1]  = W'($urandom);
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL drop_busy: got %b expected 0010", {req0_ready, req1_ready, busy, rsp_valid});
      end
      v[1] = 1'b0;
      applyStimulus();
      rdy = 1'b1;
      applyStimulus();
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, exp0}) begin
         tests_failed++;
         $display("[TB] FAIL drop_req0_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, exp0});
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         @(negedge clk);
         tests_run++;
         if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL drop_no_issue[%0d]: got %b expected 0000", i, {req0_ready, req1_ready, busy, rsp_valid});
         end
      end
   endtask

   task automatic test_random();
      logic         acc [2];
      logic         in_flight;
      int           age;
      logic         exp_id;
      logic [W-1:0] exp_data;
      logic         g;
      logic [3:0]   exp_vec;
      do_reset();
      acc       = '{1'b0, 1'b0};
      in_flight = 1'b0;
      age       = 0;
      exp_id    = 1'b0;
      exp_data  = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int k = 0; k < 2; k++) begin
            if (acc[k] || !v[k]) begin
               v[k]  = ($urandom_range(0, 2) != 0);
               op[k] = 2'($urandom_range(0, 3));
               a[k]  = W'($urandom);
               b[k]  = W'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
               v[k] = 1'b0;
            end
         end
         acc = '{1'b0, 1'b0};
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus();
         @(negedge clk);
         if (!in_flight) begin
            g       = ref_grant(v[0], v[1], lastg);
            exp_vec = {v[0] && !g, v[1] && g, 2'b00};
            tests_run++;
            if ({req0_ready, req1_ready, busy, rsp_valid} !== exp_vec) begin
               tests_failed++;
               $display("[TB] FAIL random_idle[%0d]: got %b expected %b", cyc, {req0_ready, req1_ready, busy, rsp_valid}, exp_vec);
            end
            if (v[0] || v[1]) begin
               in_flight = 1'b1;
               age       = 0;
               exp_id    = g;
               exp_data  = ref_op(op[g], a[g], b[g]);
               lastg     = g;
               acc[g]    = 1'b1;
            end
         end else begin
            age++;
            exp_vec = (age == 1) ? 4'b0010 : 4'b0011;
            tests_run++;
            if ({req0_ready, req1_ready, busy, rsp_valid} !== exp_vec) begin
               tests_failed++;
               $display("[TB] FAIL random_busy[%0d]: got %b expected %b", cyc, {req0_ready, req1_ready, busy, rsp_valid}, exp_vec);
            end
            if (age >= 2) begin
               tests_run++;
               if ({rsp_id, rsp_data} !== {exp_id, exp_data}) begin
                  tests_failed++;
                  $display("[TB] FAIL random_rsp[%0d]: got %b expected %b", cyc, {rsp_id, rsp_data}, {exp_id, exp_data});
               end
               if (rdy) in_flight = 1'b0;
            end
         end
      end
      v = '{1'b0, 1'b0};
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_i        = 1'b1;
      rdy          = 1'b0;
      v            = '{1'b0, 1'b0};
      op           = '{2'b00, 2'b00};
      a            = '{'0, '0};
      b            = '{'0, '0};
      lastg        = 1'b1;
      rst          = 1'b1;
      rsp_ready    = 1'b0;
      req0_valid   = 1'b0;
      req1_valid   = 1'b0;
      req0_op      = 2'b00;
      req1_op      = 2'b00;
      req0_a       = '0;
      req0_b       = '0;
      req1_a       = '0;
      req1_b       = '0;
      test_reset();
      test_not_req0();
      test_xor_stall();
      test_contention();
      test_rst_exec();
      test_drop_valid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
